// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register file between the core and a debug requester
//
// The core owns the register file with zero-latency passthrough. A debug request
// stalls the core for one cycle (byte access or pair read) or two cycles (pair
// write). A request waiting behind a busy core is granted after at most
// STARVE_MAX cycles.
//
// Optional feature macro: RF_ARB_WPROT_EN
//   When defined, a debug write that targets a register with its WPROT_MASK bit
//   set issues no write enable and returns dbg_err with dbg_ack.
//   When undefined, WPROT_MASK is ignored and dbg_err is tied to 0.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   core_*                      core register-file request (valid, selects, we, move, add, const, din)
//   core_stall                  registered; core must hold its request while high
//   rf_*                        register-file control outputs and A/B read data inputs
//   dbg_req/we/pair/addr/wdata  debug request, held high until dbg_ack
//   dbg_ack/rdata/err           one-cycle completion pulse, held read data, write-refused flag
module regfile_port_arbiter #(
    parameter int          STARVE_MAX = 8,
    parameter logic [15:0] WPROT_MASK = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic [3:0]  core_a_sel,
    input  logic [3:0]  core_b_sel,
    input  logic        core_we,
    input  logic        core_move,
    input  logic        core_add,
    input  logic [8:0]  core_const,
    input  logic [7:0]  core_din,
    output logic        core_stall,
    output logic [3:0]  rf_a_sel,
    output logic [3:0]  rf_b_sel,
    output logic        rf_we,
    output logic        rf_move,
    output logic        rf_add,
    output logic [8:0]  rf_const,
    output logic [7:0]  rf_din,
    input  logic [7:0]  rf_outA,
    input  logic [7:0]  rf_outB,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_pair,
    input  logic [3:0]  dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic        dbg_err
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, WAIT, XFER_LO, XFER_HI, ACK} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, pair_q;
    logic [3:0]     addr_q;
    logic [15:0]    wdata_q;
    logic [15:0]    rdata_q;
    logic           stall_q, ack_q;
    logic           prot;
    logic           dbg_own, hi;
    logic [3:0]     even_addr, odd_addr;

    assign even_addr = {addr_q[3:1], 1'b0};
    assign odd_addr  = {addr_q[3:1], 1'b1};

`ifdef RF_ARB_WPROT_EN
    logic err_q;
    // a pair write is refused if either byte of the pair is protected
    assign prot    = pair_q ? (WPROT_MASK[even_addr] | WPROT_MASK[odd_addr]) : WPROT_MASK[addr_q];
    assign dbg_err = err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= (state_d == ACK) && we_q && prot;
    end
`else
    logic unused_wprot;
    assign unused_wprot = ^WPROT_MASK;
    assign prot         = 1'b0;
    assign dbg_err      = 1'b0;
`endif

    // state register and debug datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            pair_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= (state_d == XFER_LO) || (state_d == XFER_HI);
            ack_q   <= state_d == ACK;
            if (state_d == XFER_LO) begin
                we_q    <= dbg_we;
                pair_q  <= dbg_pair;
                addr_q  <= dbg_addr;
                wdata_q <= dbg_wdata;
            end
            if (state_q == XFER_LO && !we_q)
                rdata_q <= pair_q ? {rf_outB, rf_outA} : {8'h00, rf_outA};
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (dbg_req) begin
                if (!core_valid || STARVE_MAX == 0) state_d = XFER_LO;
                else begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: if (!dbg_req) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (!core_valid || cnt_q == CW'(STARVE_MAX)) begin
                state_d = XFER_LO;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
            XFER_LO: state_d = (we_q && pair_q) ? XFER_HI : ACK;
            XFER_HI: state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    // output logic; write-type strobes are forced low while reset is asserted
    always_comb begin
        dbg_own  = (state_q == XFER_LO) || (state_q == XFER_HI);
        hi       = state_q == XFER_HI;
        rf_a_sel = dbg_own ? (hi ? odd_addr : (pair_q ? even_addr : addr_q)) : core_a_sel;
        rf_b_sel = dbg_own ? odd_addr : core_b_sel;
        rf_we    = reset && (dbg_own ? (we_q && !prot) : (core_valid && core_we));
        rf_move  = reset && !dbg_own && core_valid && core_move;
        rf_add   = reset && !dbg_own && core_valid && core_add;
        rf_const = dbg_own ? 9'h000 : core_const;
        rf_din   = dbg_own ? (hi ? wdata_q[15:8] : wdata_q[7:0]) : core_din;
    end

    assign core_stall = stall_q;
    assign dbg_ack    = ack_q;
    assign dbg_rdata  = rdata_q;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed self-checking bench with a byte register-file model
module tb_regfile_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_valid = 1'b0;
    logic [3:0]  core_a_sel = '0, core_b_sel = '0;
    logic        core_we = 1'b0, core_move = 1'b0, core_add = 1'b0;
    logic [8:0]  core_const = '0;
    logic [7:0]  core_din = '0;
    logic        core_stall;
    logic [3:0]  rf_a_sel, rf_b_sel;
    logic        rf_we, rf_move, rf_add;
    logic [8:0]  rf_const;
    logic [7:0]  rf_din, rf_outA, rf_outB;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_pair = 1'b0;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        dbg_ack, dbg_err;
    logic [15:0] dbg_rdata;
    logic [7:0]  regs [16];
    int          checks = 0;
    int          errors = 0;

`ifdef RF_ARB_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_port_arbiter #(.STARVE_MAX(8), .WPROT_MASK(16'h8000)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_a_sel(core_a_sel), .core_b_sel(core_b_sel),
        .core_we(core_we), .core_move(core_move), .core_add(core_add),
        .core_const(core_const), .core_din(core_din), .core_stall(core_stall),
        .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel), .rf_we(rf_we), .rf_move(rf_move),
        .rf_add(rf_add), .rf_const(rf_const), .rf_din(rf_din),
        .rf_outA(rf_outA), .rf_outB(rf_outB),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_pair(dbg_pair), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err)
    );

    always @(posedge clk) if (rf_we) regs[rf_a_sel] <= rf_din;
    assign rf_outA = regs[rf_a_sel];
    assign rf_outB = regs[rf_b_sel];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_go(input logic we, input logic pair, input logic [3:0] addr, input logic [15:0] wd);
        dbg_req = 1'b1; dbg_we = we; dbg_pair = pair; dbg_addr = addr; dbg_wdata = wd;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_stall", 16'(core_stall), 16'h0);
        chk("rst_ack", 16'(dbg_ack), 16'h0);
        chk("rst_err", 16'(dbg_err), 16'h0);
        chk("rst_rdata", dbg_rdata, 16'h0);
        chk("rst_we", 16'(rf_we), 16'h0);
        reset = 1'b1;
        @(negedge clk);
        // single write r3 = A5 with idle core
        dbg_go(1'b1, 1'b0, 4'd3, 16'h00A5);
        @(negedge clk);
        chk("sw_we", 16'(rf_we), 16'h1);
        chk("sw_asel", 16'(rf_a_sel), 16'h3);
        chk("sw_din", 16'(rf_din), 16'hA5);
        chk("sw_stall", 16'(core_stall), 16'h1);
        chk("sw_noack", 16'(dbg_ack), 16'h0);
        @(negedge clk);
        chk("sw_ack", 16'(dbg_ack), 16'h1);
        chk("sw_stall_off", 16'(core_stall), 16'h0);
        chk("sw_err", 16'(dbg_err), 16'h0);
        dbg_req = 1'b0;
        @(negedge clk);
        chk("sw_ack_pulse", 16'(dbg_ack), 16'h0);
        chk("sw_r3", 16'(regs[3]), 16'hA5);
        // pair write addr 5 -> r4=EF, r5=BE
        dbg_go(1'b1, 1'b1, 4'd5, 16'hBEEF);
        @(negedge clk);
        chk("pw_lo_asel", 16'(rf_a_sel), 16'h4);
        chk("pw_lo_din", 16'(rf_din), 16'hEF);
        chk("pw_lo_we", 16'(rf_we), 16'h1);
        chk("pw_lo_stall", 16'(core_stall), 16'h1);
        @(negedge clk);
        chk("pw_hi_asel", 16'(rf_a_sel), 16'h5);
        chk("pw_hi_din", 16'(rf_din), 16'hBE);
        chk("pw_hi_we", 16'(rf_we), 16'h1);
        chk("pw_hi_stall", 16'(core_stall), 16'h1);
        chk("pw_hi_noack", 16'(dbg_ack), 16'h0);
        @(negedge clk);
        chk("pw_ack", 16'(dbg_ack), 16'h1);
        chk("pw_stall_off", 16'(core_stall), 16'h0);
        dbg_req = 1'b0;
        @(negedge clk);
        chk("pw_r4", 16'(regs[4]), 16'hEF);
        chk("pw_r5", 16'(regs[5]), 16'hBE);
        // core preloads r8=34, r9=12 through the passthrough
        core_valid = 1'b1; core_we = 1'b1; core_a_sel = 4'd8; core_din = 8'h34;
        @(negedge clk);
        chk("core_r8", 16'(regs[8]), 16'h34);
        core_a_sel = 4'd9; core_din = 8'h12;
        @(negedge clk);
        chk("core_r9", 16'(regs[9]), 16'h12);
        core_we = 1'b0; core_add = 1'b1; core_a_sel = 4'd0; core_const = 9'h1FF;
        @(negedge clk);
        chk("add_pass", 16'(rf_add), 16'h1);
        chk("add_const", 16'(rf_const), 16'h1FF);
        chk("add_asel", 16'(rf_a_sel), 16'h0);
        chk("add_we", 16'(rf_we), 16'h0);
        core_valid = 1'b0; core_add = 1'b0;
        dbg_go(1'b0, 1'b1, 4'd8, 16'h0000);
        @(negedge clk);
        chk("pr_asel", 16'(rf_a_sel), 16'h8);
        chk("pr_bsel", 16'(rf_b_sel), 16'h9);
        chk("pr_we", 16'(rf_we), 16'h0);
        chk("pr_stall", 16'(core_stall), 16'h1);
        @(negedge clk);
        chk("pr_ack", 16'(dbg_ack), 16'h1);
        chk("pr_rdata", dbg_rdata, 16'h1234);
        dbg_req = 1'b0;
        @(negedge clk);
        chk("pr_hold", dbg_rdata, 16'h1234);
        // busy core: single read r4 waits STARVE_MAX cycles
        core_valid = 1'b1; core_move = 1'b1; core_a_sel = 4'd2; core_b_sel = 4'd7;
        dbg_go(1'b0, 1'b0, 4'd4, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("wait_stall", 16'(core_stall), 16'h0);
            chk("wait_move", 16'(rf_move), 16'h1);
        end
        @(negedge clk);
        chk("sv_stall", 16'(core_stall), 16'h1);
        chk("sv_asel", 16'(rf_a_sel), 16'h4);
        chk("sv_move", 16'(rf_move), 16'h0);
        @(negedge clk);
        chk("sv_ack", 16'(dbg_ack), 16'h1);
        chk("sv_rdata", dbg_rdata, 16'h00EF);
        chk("sv_stall_off", 16'(core_stall), 16'h0);
        chk("sv_restore_a", 16'(rf_a_sel), 16'h2);
        chk("sv_restore_b", 16'(rf_b_sel), 16'h7);
        chk("sv_restore_mv", 16'(rf_move), 16'h1);
        dbg_req = 1'b0; core_valid = 1'b0; core_move = 1'b0;
        @(negedge clk);
        // reset during XFER_HI of pair write to 2
        dbg_go(1'b1, 1'b1, 4'd2, 16'h6655);
        @(negedge clk);
        chk("rs_lo_asel", 16'(rf_a_sel), 16'h2);
        @(negedge clk);
        chk("rs_hi_asel", 16'(rf_a_sel), 16'h3);
        reset = 1'b0;
        #1;
        chk("rs_we", 16'(rf_we), 16'h0);
        chk("rs_stall", 16'(core_stall), 16'h0);
        chk("rs_rdata", dbg_rdata, 16'h0);
        @(negedge clk);
        chk("rs_noack", 16'(dbg_ack), 16'h0);
        reset = 1'b1; dbg_req = 1'b0; core_a_sel = 4'd6;
        @(negedge clk);
        chk("rs_r2", 16'(regs[2]), 16'h55);
        chk("rs_r3", 16'(regs[3]), 16'hA5);
        chk("rs_idle_asel", 16'(rf_a_sel), 16'h6);
        chk("rs_idle_stall", 16'(core_stall), 16'h0);
        chk("rs_idle_ack", 16'(dbg_ack), 16'h0);
        // pair write to protected pair 14/15
        dbg_go(1'b1, 1'b1, 4'd14, 16'h7766);
        @(negedge clk);
        chk("wp_lo_asel", 16'(rf_a_sel), 16'hE);
        chk("wp_lo_we", 16'(rf_we), WP ? 16'h0 : 16'h1);
        chk("wp_lo_stall", 16'(core_stall), 16'h1);
        @(negedge clk);
        chk("wp_hi_asel", 16'(rf_a_sel), 16'hF);
        chk("wp_hi_we", 16'(rf_we), WP ? 16'h0 : 16'h1);
        @(negedge clk);
        chk("wp_ack", 16'(dbg_ack), 16'h1);
        chk("wp_err", 16'(dbg_err), WP ? 16'h1 : 16'h0);
        dbg_req = 1'b0;
        @(negedge clk);
        chk("wp_ack_pulse", 16'(dbg_ack), 16'h0);
        if (!WP) begin
            chk("wp_r14", 16'(regs[14]), 16'h66);
            chk("wp_r15", 16'(regs[15]), 16'h77);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
